// File: rtl/rs_arbiter.sv
// rs_arbiter: round-robin owner of the shared RS decoder.
// Grants one TS channel per row, routes bytes, watchdog release.
//
// Ports:
//   clk, reset               clock, sync active-high reset
//   tsN_req                  channel N has a row ready
//   tsN_rs_mode/en_in/din    channel N mode, byte strobe, byte in
//   tsN_gnt                  channel N owns the decoder
//   tsN_rs_en_out/dout       decoder output routed to channel N
//   tsN_row_done             one-cycle pulse: channel N row finished
//   rs_mode/en_in/din        mode, strobe, byte toward the decoder
//   rs_row_finish/en_out/dout  decoder row-done, strobe, byte
//   rs_timeout               one-cycle pulse on watchdog release
//   busy                     high whenever not IDLE
`timescale 1ns/1ps
module rs_arbiter #(
  parameter int TIMEOUT = 65535,
  parameter int CNT_W   = 16,
  parameter int GAP_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ts0_req,
  input  logic       ts1_req,
  input  logic [1:0] ts0_rs_mode,
  input  logic [1:0] ts1_rs_mode,
  input  logic       ts0_rs_en_in,
  input  logic       ts1_rs_en_in,
  input  logic [7:0] ts0_rs_din,
  input  logic [7:0] ts1_rs_din,
  output logic       ts0_gnt,
  output logic       ts1_gnt,
  output logic       ts0_rs_en_out,
  output logic       ts1_rs_en_out,
  output logic [7:0] ts0_rs_dout,
  output logic [7:0] ts1_rs_dout,
  output logic       ts0_row_done,
  output logic       ts1_row_done,
  output logic [1:0] rs_mode,
  output logic       rs_en_in,
  output logic [7:0] rs_din,
  input  logic       rs_row_finish,
  input  logic       rs_en_out,
  input  logic [7:0] rs_dout,
  output logic       rs_timeout,
  output logic       busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  logic [1:0]       state;
  logic             last_owner;
  logic [CNT_W-1:0] wd_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             own0;
  logic             own1;
  logic             wd_expired;

  assign own0       = (state == S_OWN0);
  assign own1       = (state == S_OWN1);
  assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      last_owner   <= 1'b1;
      wd_cnt       <= '0;
      gap_cnt      <= '0;
      rs_mode      <= 2'b00;
      ts0_row_done <= 1'b0;
      ts1_row_done <= 1'b0;
      rs_timeout   <= 1'b0;
    end else begin
      ts0_row_done <= 1'b0;
      ts1_row_done <= 1'b0;
      rs_timeout   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          wd_cnt <= '0;
          // On a tie the channel that did not own last wins.
          if (ts0_req && (!ts1_req || last_owner)) begin
            state      <= S_OWN0;
            last_owner <= 1'b0;
            rs_mode    <= ts0_rs_mode;
          end else if (ts1_req) begin
            state      <= S_OWN1;
            last_owner <= 1'b1;
            rs_mode    <= ts1_rs_mode;
          end
        end
        S_OWN0, S_OWN1: begin
          if (rs_row_finish || wd_expired) begin
            // A finish in the expiry cycle counts as a clean finish.
            ts0_row_done <= rs_row_finish && own0;
            ts1_row_done <= rs_row_finish && own1;
            rs_timeout   <= !rs_row_finish;
            state        <= S_GAP;
            gap_cnt      <= GAP_W'(GAP_CYC - 1);
            wd_cnt       <= '0;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          wd_cnt <= '0;
          if (gap_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ts0_gnt = own0;
  assign ts1_gnt = own1;
  assign busy    = (state != S_IDLE);

  always_comb begin
    rs_en_in = 1'b0;
    rs_din   = 8'h00;
    unique case (1'b1)
      own0: begin
        rs_en_in = ts0_rs_en_in;
        rs_din   = ts0_rs_din;
      end
      own1: begin
        rs_en_in = ts1_rs_en_in;
        rs_din   = ts1_rs_din;
      end
      default: begin
        rs_en_in = 1'b0;
        rs_din   = 8'h00;
      end
    endcase
  end

  assign ts0_rs_en_out = own0 & rs_en_out;
  assign ts1_rs_en_out = own1 & rs_en_out;
  assign ts0_rs_dout   = own0 ? rs_dout : 8'h00;
  assign ts1_rs_dout   = own1 ? rs_dout : 8'h00;

endmodule

// File: tb/tb_rs_arbiter.sv
// tb_rs_arbiter: random rows against a row-level reference model.
// Driver queues expected grants; a monitor checks them as they occur.
`timescale 1ns/1ps
module tb_rs_arbiter;

  localparam int TO  = 20;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ts0_req = 0, ts1_req = 0;
  logic [1:0] ts0_rs_mode = 0, ts1_rs_mode = 0;
  logic       ts0_rs_en_in = 0, ts1_rs_en_in = 0;
  logic [7:0] ts0_rs_din = 0, ts1_rs_din = 0;
  logic       ts0_gnt, ts1_gnt;
  logic       ts0_rs_en_out, ts1_rs_en_out;
  logic [7:0] ts0_rs_dout, ts1_rs_dout;
  logic       ts0_row_done, ts1_row_done;
  logic [1:0] rs_mode;
  logic       rs_en_in;
  logic [7:0] rs_din;
  logic       rs_row_finish = 0;
  logic       rs_en_out = 0;
  logic [7:0] rs_dout = 0;
  logic       rs_timeout;
  logic       busy;

  always #5 clk = ~clk;

  rs_arbiter #(.TIMEOUT(TO), .CNT_W(16), .GAP_CYC(GAP)) dut (
    .clk(clk), .reset(reset),
    .ts0_req(ts0_req), .ts1_req(ts1_req),
    .ts0_rs_mode(ts0_rs_mode), .ts1_rs_mode(ts1_rs_mode),
    .ts0_rs_en_in(ts0_rs_en_in), .ts1_rs_en_in(ts1_rs_en_in),
    .ts0_rs_din(ts0_rs_din), .ts1_rs_din(ts1_rs_din),
    .ts0_gnt(ts0_gnt), .ts1_gnt(ts1_gnt),
    .ts0_rs_en_out(ts0_rs_en_out), .ts1_rs_en_out(ts1_rs_en_out),
    .ts0_rs_dout(ts0_rs_dout), .ts1_rs_dout(ts1_rs_dout),
    .ts0_row_done(ts0_row_done), .ts1_row_done(ts1_row_done),
    .rs_mode(rs_mode), .rs_en_in(rs_en_in), .rs_din(rs_din),
    .rs_row_finish(rs_row_finish), .rs_en_out(rs_en_out),
    .rs_dout(rs_dout), .rs_timeout(rs_timeout), .busy(busy)
  );

  typedef struct {
    bit       owner;
    bit [1:0] mode;
    bit       tmo;
    int       dur;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   mon_en = 1;
  bit   in_g = 0;

  task automatic check(input bit ok, input string name,
                       input string detail);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic bit all_zero();
    return !ts0_gnt && !ts1_gnt && !ts0_rs_en_out && !ts1_rs_en_out
        && ts0_rs_dout == 0 && ts1_rs_dout == 0 && !ts0_row_done
        && !ts1_row_done && rs_mode == 0 && !rs_en_in && rs_din == 0
        && !rs_timeout && !busy;
  endfunction

  function automatic string outs();
    return $sformatf("gnt=%b%b busy=%b mode=%0d en_in=%b din=%h eo=%b%b do=%h/%h done=%b%b tmo=%b",
      ts1_gnt, ts0_gnt, busy, rs_mode, rs_en_in, rs_din,
      ts1_rs_en_out, ts0_rs_en_out, ts1_rs_dout, ts0_rs_dout,
      ts1_row_done, ts0_row_done, rs_timeout);
  endfunction

  // Byte traffic changes shortly after each rising edge so that it is
  // stable whenever the monitor samples on the falling edge.
  initial forever begin
    @(posedge clk);
    #2;
    ts0_rs_en_in = 1'($urandom);
    ts1_rs_en_in = 1'($urandom);
    ts0_rs_din   = 8'($urandom);
    ts1_rs_din   = 8'($urandom);
    rs_en_out    = 1'($urandom);
    rs_dout      = 8'($urandom);
  end

  // Monitor
  initial begin
    bit   own;
    bit   g0, g1, ok;
    int   dur;
    int   since_rel;
    exp_t cur;
    own = 0; dur = 0; since_rel = 100;
    cur = '{owner: 0, mode: 0, tmo: 0, dur: 0};
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        g0 = ts0_gnt;
        g1 = ts1_gnt;
        if (g0 && g1) check(0, "exclusive", outs());
        if (!in_g && (g0 || g1)) begin
          if (sb.size() == 0) begin
            check(0, "unexpected_grant", outs());
          end else begin
            cur = sb.pop_front();
            check(g1 == cur.owner, "owner",
              $sformatf("got ts%0d want ts%0d", g1, cur.owner));
            check(since_rel >= GAP + 1, "gap_before_grant",
              $sformatf("got %0d want >=%0d", since_rel, GAP + 1));
          end
          in_g = 1; own = g1; dur = 0;
        end
        if (in_g && (own ? g1 : g0)) begin
          dur++;
          check(rs_mode == cur.mode, "mode_hold",
            $sformatf("got %0d want %0d", rs_mode, cur.mode));
          ok = rs_en_in == (own ? ts1_rs_en_in : ts0_rs_en_in)
            && rs_din == (own ? ts1_rs_din : ts0_rs_din)
            && (own ? ts1_rs_en_out : ts0_rs_en_out) == rs_en_out
            && (own ? ts1_rs_dout : ts0_rs_dout) == rs_dout
            && (own ? ts0_rs_en_out : ts1_rs_en_out) == 0
            && (own ? ts0_rs_dout : ts1_rs_dout) == 8'h00;
          check(ok, "route", $sformatf("%s want owner ts%0d din=%h/%h dec=%b/%h",
            outs(), own, ts1_rs_din, ts0_rs_din, rs_en_out, rs_dout));
          check(!ts0_row_done && !ts1_row_done && !rs_timeout,
                "pulse_in_grant", outs());
        end else if (in_g) begin
          in_g = 0;
          since_rel = 1;
          check(dur == cur.dur, "grant_len",
            $sformatf("got %0d want %0d", dur, cur.dur));
          ok = ts0_row_done == (!own && !cur.tmo)
            && ts1_row_done == (own && !cur.tmo)
            && rs_timeout == cur.tmo && busy;
          check(ok, "release", $sformatf("%s want tmo=%b owner ts%0d",
            outs(), cur.tmo, own));
        end else begin
          if (since_rel < 100) since_rel++;
          ok = !ts0_row_done && !ts1_row_done && !rs_timeout
            && !rs_en_in && rs_din == 0 && !ts0_rs_en_out
            && !ts1_rs_en_out && ts0_rs_dout == 0 && ts1_rs_dout == 0;
          check(ok, "idle_quiet", outs());
          check(busy == (since_rel <= GAP), "busy_gap",
            $sformatf("got %b want %b at %0d after release",
              busy, since_rel <= GAP, since_rel));
        end
      end
    end
  end

  // Driver with row-level reference model
  initial begin
    bit   last;
    int   r, len, w;
    bit   owner;
    exp_t e;
    last = 1;
    repeat (3) @(negedge clk);
    check(all_zero(), "reset_state", outs());
    reset = 0;
    for (int n = 0; n < 60; n++) begin
      int extra;
      extra = $urandom_range(0, 3);
      ts0_req = 0;
      ts1_req = 0;
      for (int x = 0; x < extra; x++) begin
        rs_row_finish = 1'($urandom);
        @(negedge clk);
      end
      rs_row_finish = 0;
      r = $urandom_range(1, 3);
      ts0_req = r[0];
      ts1_req = r[1];
      ts0_rs_mode = 2'($urandom);
      ts1_rs_mode = 2'($urandom);
      if ($urandom_range(0, 5) == 0) len = TO;
      else len = $urandom_range(1, TO + 4);
      if (r == 3) owner = !last;
      else owner = (r == 2);
      last = owner;
      e.owner = owner;
      e.mode  = owner ? ts1_rs_mode : ts0_rs_mode;
      e.tmo   = (len > TO);
      e.dur   = (len > TO) ? TO : len;
      sb.push_back(e);
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!(ts0_gnt || ts1_gnt) && w < 20);
      if (!(ts0_gnt || ts1_gnt)) begin
        check(0, "grant_wait", $sformatf("no grant after %0d cycles", w));
        void'(sb.pop_back());
        continue;
      end
      for (int k = 0; k < TO + 10; k++) begin
        rs_row_finish = (k == len - 1);
        if ($urandom_range(0, 3) == 0) ts0_rs_mode = 2'($urandom);
        if ($urandom_range(0, 3) == 0) ts1_rs_mode = 2'($urandom);
        if ($urandom_range(0, 7) == 0) ts0_req = 0;
        if ($urandom_range(0, 7) == 0) ts1_req = 0;
        @(negedge clk);
        if (!(ts0_gnt || ts1_gnt)) break;
      end
      rs_row_finish = 0;
    end
    ts0_req = 0;
    ts1_req = 0;
    repeat (6) @(negedge clk);
    check(sb.size() == 0 && !in_g, "drain",
      $sformatf("pending=%0d in_grant=%b", sb.size(), in_g));
    mon_en = 0;

    // Mid-row reset, then tie and spurious-finish checks
    ts0_req = 1;
    ts0_rs_mode = 2'b11;
    @(negedge clk);
    check(ts0_gnt && rs_mode == 2'b11, "dir_grant", outs());
    ts0_req = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    check(all_zero(), "mid_row_reset", outs());
    reset = 0;
    ts0_req = 1;
    ts1_req = 1;
    ts0_rs_mode = 2'b01;
    @(negedge clk);
    check(ts0_gnt && !ts1_gnt && rs_mode == 2'b01, "tie_after_reset",
          outs());
    ts0_req = 0;
    ts1_req = 0;
    rs_row_finish = 1;
    @(negedge clk);
    check(ts0_row_done && !ts0_gnt && busy && !rs_timeout, "dir_done",
          outs());
    rs_row_finish = 0;
    repeat (2) @(negedge clk);
    check(!busy, "dir_idle", outs());
    rs_row_finish = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check(!ts0_row_done && !ts1_row_done && !rs_timeout && !busy,
            "spurious_finish", outs());
    end
    rs_row_finish = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
